// File: rtl/act_requant_packer.sv
// Requantizes sign-magnitude MAC results to 8-bit sign-magnitude activations
// and packs N of them into one vector presented with a valid/ready handshake.
module act_requant_packer #(
    parameter int N     = 30,
    parameter int IN_W  = 20,
    parameter int SHIFT = 7,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*8-1:0]    out_data,
    output logic [15:0]       sat_count
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int MAG_W = IN_W - 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             accept;
    logic [7:0]       lane_p0;
    logic             sat_p0;

    function automatic logic [MAG_W-1:0] shifted_mag(input logic [IN_W-1:0] d);
        return d[MAG_W-1:0] >> SHIFT;
    endfunction

    // Negative inputs clamped by ReLU never count as saturation events.
    function automatic logic is_sat(input logic [IN_W-1:0] d);
        return !(d[IN_W-1] && (RELU != 0)) && (shifted_mag(d) > MAG_W'(127));
    endfunction

    function automatic logic [7:0] requant(input logic [IN_W-1:0] d);
        logic [MAG_W-1:0] m;
        logic [6:0]       mag;
        m   = shifted_mag(d);
        mag = (m > MAG_W'(127)) ? 7'h7F : m[6:0];
        if (d[IN_W-1] && (RELU != 0))
            return 8'h00;
        return {d[IN_W-1] && (mag != 7'd0), mag};
    endfunction

    assign in_ready  = !rst && ((state == FILL) || ((state == FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);
    assign lane_p0   = requant(in_data);
    assign sat_p0    = is_sat(in_data);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            FILL: begin
                if (accept) begin
                    if (idx == IDX_W'(N - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = FULL;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                // Drain cycle may also take lane 0 of the next vector.
                if (out_ready) begin
                    state_nxt = FILL;
                    if (accept)
                        idx_nxt = IDX_W'(1);
                end
            end
            default: begin
                state_nxt = FILL;
                idx_nxt   = '0;
            end
        endcase
    end

    // Stage boundary: lane register, control state and event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            out_data  <= '0;
            sat_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (idx == IDX_W'(i))
                        out_data[8*i +: 8] <= lane_p0;
                end
                if (sat_p0 && (sat_count != 16'hFFFF))
                    sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_act_requant_packer.sv
// Scoreboard bench: two packers (ReLU on/off) share one input stream and are
// checked against an arithmetic reference of the requantization rules.
module tb_act_requant_packer;

    localparam int N     = 4;
    localparam int IN_W  = 18;
    localparam int SHIFT = 4;
    localparam int MAG_W = IN_W - 1;

    typedef logic [N*8-1:0] word_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            ir1, ov1, ir0, ov0;
    logic [N*8-1:0]  od1, od0;
    logic [15:0]     sc1, sc0;

    always #5 clk = ~clk;

    act_requant_packer #(.N(N), .IN_W(IN_W), .SHIFT(SHIFT), .RELU(1)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .sat_count(sc1)
    );

    act_requant_packer #(.N(N), .IN_W(IN_W), .SHIFT(SHIFT), .RELU(0)) dut_signed (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .sat_count(sc0)
    );

    int    checks = 0;
    int    errors = 0;
    word_t q1[$];
    word_t q0[$];
    word_t acc1 = '0;
    word_t acc0 = '0;
    int    fill_cnt = 0;
    bit    pending = 1'b0;
    int    sat1 = 0;
    int    sat0 = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: divide the magnitude, clamp, apply ReLU, no negative zero.
    function automatic logic [7:0] ref_lane(input bit s, input int mag, input bit relu, output bit sat);
        int q;
        sat = 1'b0;
        q   = mag / (1 << SHIFT);
        if (s && relu)
            return 8'h00;
        if (q > 127) begin
            q   = 127;
            sat = 1'b1;
        end
        if (q == 0)
            return 8'h00;
        return 8'((s ? 128 : 0) + q);
    endfunction

    task automatic tick(input bit v, input bit s, input int mag, output bit acc);
        bit         exp_rdy, sa, sb;
        logic [7:0] l1, l0;
        in_valid = v;
        in_data  = {s, MAG_W'(mag)};
        @(negedge clk);
        exp_rdy = !(pending && !out_ready);
        check("in_ready_relu", word_t'(ir1), word_t'(exp_rdy));
        check("in_ready_signed", word_t'(ir0), word_t'(exp_rdy));
        acc = v && exp_rdy;
        if (pending && out_ready)
            pending = 1'b0;
        if (acc) begin
            l1 = ref_lane(s, mag, 1'b1, sa);
            l0 = ref_lane(s, mag, 1'b0, sb);
            acc1[8*fill_cnt +: 8] = l1;
            acc0[8*fill_cnt +: 8] = l0;
            if (sa && sat1 < 65535) sat1++;
            if (sb && sat0 < 65535) sat0++;
            fill_cnt++;
            if (fill_cnt == N) begin
                q1.push_back(acc1);
                q0.push_back(acc0);
                fill_cnt = 0;
                pending  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s, input int mag);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, s, mag, a);
            if (a) break;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: input %0d/%0d never accepted", s, mag);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++)
            tick(1'b0, 1'b0, 0, a);
    endtask

    task automatic check_sat();
        check("sat_count_relu", word_t'(sc1), word_t'(sat1));
        check("sat_count_signed", word_t'(sc0), word_t'(sat0));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        q1.delete();
        q0.delete();
        fill_cnt = 0;
        pending  = 1'b0;
        sat1     = 0;
        sat0     = 0;
        acc1     = '0;
        acc0     = '0;
        @(posedge clk);
        #1;
        check("reset_in_ready", word_t'({ir1, ir0}), word_t'(0));
        check("reset_out_valid", word_t'({ov1, ov0}), word_t'(0));
        check("reset_out_data_relu", od1, word_t'(0));
        check("reset_out_data_signed", od0, word_t'(0));
        check("reset_sat_count", word_t'({sc1, sc0}), word_t'(0));
        rst = 1'b0;
    endtask

    // Monitor: every presented vector must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_relu: got 1 with no vector expected at %0t", $time);
                end else begin
                    check("vector_relu", od1, q1[0]);
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (ov0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_signed: got 1 with no vector expected at %0t", $time);
                end else begin
                    check("vector_signed", od0, q0[0]);
                    if (out_ready) void'(q0.pop_front());
                end
            end
        end
    end

    initial begin
        bit a;
        bit s;
        bit v;
        int mag;

        do_reset();

        // basic pack and signed mode
        out_ready = 1'b1;
        send(1'b0, 500); send(1'b1, 73); send(1'b0, 1488); send(1'b1, 2000);
        idle(3);
        check_sat();
        send(1'b1, 500); send(1'b1, 5); send(1'b0, 2047); send(1'b0, 2048);
        idle(3);
        check_sat();
        check("sat_count_signed_mode", word_t'(sc0), word_t'(1));

        // backpressure: completed vector held while input waits
        out_ready = 1'b0;
        send(1'b0, 16); send(1'b0, 32); send(1'b0, 48); send(1'b0, 64);
        for (int k = 0; k < 10; k++)
            tick(1'b1, 1'b0, 80, a);
        out_ready = 1'b1;
        send(1'b0, 80); send(1'b0, 96); send(1'b0, 112); send(1'b0, 128);
        idle(3);

        // back-to-back vectors
        for (int i = 1; i <= 12; i++)
            send(1'b0, 16 * i);
        idle(3);

        // reset mid-fill discards partial vector
        send(1'b0, 100); send(1'b1, 300);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send(1'b0, 16);
        idle(3);
        check_sat();

        // randomized traffic with random backpressure and gaps
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            v         = ($urandom_range(0, 3) != 0);
            s         = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       mag = int'($urandom_range(0, 300));
                1:       mag = int'($urandom_range(1900, 2200));
                default: mag = int'($urandom_range(0, (1 << MAG_W) - 1));
            endcase
            tick(v, s, mag, a);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check_sat();

        // saturation counter sticks at its maximum
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++)
            send(1'b0, (1 << MAG_W) - 1);
        idle(3);
        check_sat();
        check("sat_count_limit", word_t'({sc1, sc0}), word_t'(32'hFFFF_FFFF));

        check("scoreboard_drained", word_t'(q1.size() + q0.size()), word_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_requant_packer.md
# act_requant_packer

Consumes the stream of sign-magnitude dot-product results produced by the layer's MAC units and turns them into the packed 8-bit sign-magnitude activation bus that the next layer's MAC expects as its `a` input. Each accepted result is shifted, optionally ReLU-clamped, and saturated to 7-bit magnitude. It is written into the next byte lane. When `N` lanes are filled, the vector is presented with a valid/ready handshake. The block sits between layer k's MAC array and layer k+1's MAC input register.

## Interface
- `N`, 30: activations per output vector (lanes); must be ≥ 2.
- `IN_W`, 20: input result width; MSB is sign, `[IN_W-2:0]` is magnitude.
- `SHIFT`, 7: right shift applied to the magnitude (requantization), 0 ≤ SHIFT ≤ IN_W-1.
- `RELU`, 1: 1 = negative results become 0; 0 = sign preserved.

Ports:
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a MAC result.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `in_data` input IN_W: sign-magnitude MAC result.
- `out_valid` output 1: `out_data` holds a complete vector.
- `out_ready` input 1: downstream takes the vector.
- `out_data` output N*8: lane i occupies `[8i+7:8i]` as {sign, mag[6:0]}; lane 0 is the first result accepted.
- `sat_count` output 16: number of saturation events since reset.

## Operation
- **States:**
  - FILL: collecting results.
  - FULL: vector complete, waiting for drain.
- **Counter:** `idx` ranges 0..N-1 and gives the lane to write next.
- **Accept:** an input is accepted when `in_valid && in_ready`.
- **`in_ready` rule:**
  - `in_ready = !rst && (state==FILL || (state==FULL && out_ready))`.
  - This is combinational from state and `out_ready`; `in_valid` does not influence it.
- **Per accepted result:**
  - m = magnitude >> SHIFT (truncating).
  - If m > 127: mag = 127, and `sat_count` increments.
  - Else: mag = m[6:0].
  - If sign=1 and RELU=1: lane = 8'h00. No saturation event is counted, even if the magnitude is large.
  - If mag == 0: sign forced to 0, so there is never a negative zero.
  - Otherwise the lane is {sign, mag}.
- **FILL:**
  - On accept, write lane `idx`.
  - If `idx == N-1`: set `idx` = 0, go to FULL, `out_valid` = 1.
  - Else: `idx` increments.
- **FULL:**
  - `out_data` is held stable.
  - If `out_ready`: the vector is delivered and `out_valid` = 0 next cycle, returning to FILL.
  - If an accept also happens in that cycle, the result is written to lane 0 and `idx` = 1.
- **Stale lanes:** after a drain, lanes not yet rewritten keep their old values. `out_data` is meaningful only while `out_valid` = 1.
- **`sat_count`:** saturates at 16'hFFFF and never wraps.
- **Unsupported use:** `in_data` with IN_W bits that exceed the parameter is not supported. No flush is provided; a partial vector stays pending until completed or reset.

## Timing
- **Reset values:** state = FILL, `idx` = 0, `out_valid` = 0, `out_data` = 0, `sat_count` = 0. `in_ready` = 0 while `rst` is high.
- **Reset mid-operation:** a partially filled vector is discarded, and a pending FULL vector is dropped without handshake.
- **Latency:** the N-th accept at edge t gives `out_valid` = 1 after edge t (visible in cycle t+1).
- **Throughput:**
  - With `out_ready` tied high, one result per cycle is sustained.
  - The FULL cycle overlaps with acceptance of the next vector's lane 0, so there are no bubbles.
- **Stall:** with `out_ready` low in FULL, `in_ready` = 0 and `out_data`/`out_valid` are held indefinitely.
- **Handshake rules:**
  - Downstream may assert `out_ready` at any time; it has no effect in FILL.
  - Upstream must hold `in_data` stable while `in_valid` is high and `in_ready` is low.

## Test plan
Use N=4, IN_W=18, SHIFT=4 unless noted.
1. **Basic pack (RELU=1):** feed +500, −73, +93·16=+1488, −2000 with `out_ready` = 1.
   - Expect `out_data` = {8'h00, 8'h5D, 8'h00, 8'h1F} (lane3..lane0) one cycle after the 4th accept.
   - Expect `out_valid` pulsed for 1 cycle and `sat_count` = 0.
2. **Signed mode (RELU=0):** feed −500, −5, +2047, +2048.
   - Expect lanes 0..3 = 8'h9F, 8'h00 (−5>>4 = 0, sign cleared), 8'h7F, 8'h7F.
   - Expect `sat_count` = 1 (2048>>4 = 128).
3. **Backpressure:** complete a vector with `out_ready` = 0 for 10 cycles while `in_valid` = 1.
   - Expect `in_ready` = 0 and `out_data` stable throughout.
   - Raise `out_ready`: the vector drains and the pending input lands in lane 0 in the same cycle.
4. **Back-to-back:** 12 consecutive inputs 1·16..12·16 with `out_ready` = 1.
   - Expect three vectors {4,3,2,1}, {8,7,6,5}, {12,11,10,9} (magnitudes, lane3..lane0).
   - Expect `in_ready` continuously 1.
5. **Reset mid-fill:** accept 2 inputs, pulse `rst`, then feed 4 inputs of +16.
   - Expect the vector to be all 8'h01, with no leftover lanes from before reset, and `sat_count` = 0.
6. **Saturation counter limit:** force 65 537 saturating inputs.
   - Expect `sat_count` to stick at 16'hFFFF.
